// File: rtl/gf256_inverse_seq.sv
// rtl/gf256_inverse_seq.sv - iterative GF(2^8) multiplicative inverse (x^254)
//
// Computes the inverse of a byte in GF(2^8) modulo x^8+x^4+x^3+x+1 by
// square-and-multiply: seven steps, one per clock, giving x^(2+4+...+128).
// The result feeds the S-box affine stage downstream.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   in_data is valid
//   in_ready   block can accept a byte (IDLE and not in reset)
//   in_data    byte to invert
//   out_valid  out_data holds a finished result
//   out_ready  downstream accepts the result
//   out_data   inverse of the accepted byte (0x00 maps to 0x00)
//   busy       high while iterating or holding a result
module gf256_inverse_seq #(
  parameter logic [7:0] POLY = 8'h1B
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t     state;
  logic [7:0] sq;
  logic [7:0] acc;
  logic [2:0] cnt;
  logic [7:0] sq_next;
  logic [7:0] acc_next;

  // Shift-and-add multiply; reduction folds POLY back in when bit 7 leaves.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] t;
    p = 8'h00;
    t = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[6:0], 1'b0} ^ (t[7] ? POLY : 8'h00);
    end
    return p;
  endfunction

  always_comb begin
    sq_next  = gf_mul(sq, sq);
    acc_next = gf_mul(acc, sq_next);
  end

  // Gated by rst so nothing upstream sees a ready during reset.
  assign in_ready = (state == IDLE) & ~rst;
  assign busy     = (state != IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      sq        <= 8'h00;
      acc       <= 8'h00;
      cnt       <= 3'd0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sq    <= in_data;
            acc   <= 8'h01;
            cnt   <= 3'd0;
            state <= CALC;
          end
        end
        CALC: begin
          sq  <= sq_next;
          acc <= acc_next;
          cnt <= cnt + 3'd1;
          // Last step: publish the final accumulator directly so out_valid
          // rises on the same edge the iteration finishes.
          if (cnt == 3'd6) begin
            state     <= DONE;
            out_valid <= 1'b1;
            out_data  <= acc_next;
          end
        end
        DONE: begin
          if (out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf256_inverse_seq.sv
// tb/tb_gf256_inverse_seq.sv - self-checking bench for gf256_inverse_seq
module tb_gf256_inverse_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] exp_q[$];

  gf256_inverse_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] din;
    logic [7:0] inv;
    logic [7:0] sbox;
  } vec_t;

  vec_t vecs[5];

  // Carry-less product followed by polynomial long division by 0x11B.
  function automatic logic [7:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'h0000;
    for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (16'(a) << i);
    for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (16'h011B << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [7:0] ref_inv(input logic [7:0] x);
    logic [7:0] r;
    r = 8'h00;
    if (x != 8'h00)
      for (int b = 1; b < 256; b++)
        if (ref_mul(x, 8'(b)) == 8'h01) r = 8'(b);
    return r;
  endfunction

  function automatic logic [7:0] affine(input logic [7:0] b);
    logic [7:0] c;
    logic [7:0] r;
    c = 8'h63;
    for (int i = 0; i < 8; i++)
      r[i] = b[i] ^ b[(i + 4) % 8] ^ b[(i + 5) % 8] ^ b[(i + 6) % 8] ^ b[(i + 7) % 8] ^ c[i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %02h expected %02h", name, act, expv);
    end
  endtask

  // Scoreboard: a handshake seen at the negedge completes on the next posedge.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_output: got %02h expected none", out_data);
      end else begin
        logic [7:0] x;
        x = exp_q.pop_front();
        chk("model_inv", out_data, ref_inv(x));
        if (x != 8'h00) chk("mul_is_one", ref_mul(x, out_data), 8'h01);
      end
    end
  end

  // Drive a byte, wait for acceptance; returns at accept edge + 1.
  task automatic send(input logic [7:0] x);
    logic a;
    bit   ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = x;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      a = in_ready;
      @(posedge clk);
      if (a) begin
        exp_q.push_back(x);
        ok = 1'b1;
      end
    end
    #1;
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 8'h00, 8'h01);
  endtask

  task automatic wait_out();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) ok = 1'b1;
    end
    if (!ok) chk("wait_out_timeout", 8'h00, 8'h01);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 100 && !ok; c++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) ok = 1'b1;
    end
    if (!ok) chk("drain_timeout", 8'(exp_q.size()), 8'h00);
  endtask

  initial begin
    logic a;
    int   n_acc;
    int   t0;
    int   t1;

    vecs[0] = '{8'h00, 8'h00, 8'h63};
    vecs[1] = '{8'h01, 8'h01, 8'h7C};
    vecs[2] = '{8'h02, 8'h8D, 8'h77};
    vecs[3] = '{8'hCA, 8'h53, 8'h74};
    vecs[4] = '{8'hFF, 8'h1C, 8'h16};

    rst = 1'b1;
    in_valid = 1'b0;
    in_data = 8'h00;
    out_ready = 1'b1;
    #2;
    chk("rst_in_ready", {7'b0, in_ready}, 8'h00);
    chk("rst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_busy", {7'b0, busy}, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("idle_in_ready", {7'b0, in_ready}, 8'h01);

    // Latency: accept at E0, result after E7, idle again after E8.
    send(8'h53);
    chk("lat_in_ready_drop", {7'b0, in_ready}, 8'h00);
    chk("lat_busy", {7'b0, busy}, 8'h01);
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      #1;
      chk("lat_no_valid_early", {7'b0, out_valid}, 8'h00);
    end
    @(posedge clk);
    #1;
    chk("lat_valid_e7", {7'b0, out_valid}, 8'h01);
    chk("lat_data_e7", out_data, 8'hCA);
    @(posedge clk);
    #1;
    chk("lat_valid_clear", {7'b0, out_valid}, 8'h00);
    chk("lat_in_ready_back", {7'b0, in_ready}, 8'h01);
    drain();

    // Known pairs and their S-box values through the affine stage.
    for (int i = 0; i < 5; i++) begin
      send(vecs[i].din);
      wait_out();
      chk("tbl_inv", out_data, vecs[i].inv);
      chk("tbl_sbox", affine(out_data), vecs[i].sbox);
      drain();
    end

    // Exhaustive, back to back; the scoreboard checks every result.
    for (int x = 0; x < 256; x++) send(8'(x));
    drain();

    // Backpressure.
    out_ready = 1'b0;
    send(8'h53);
    wait_out();
    for (int k = 0; k < 10; k++) begin
      chk("bp_valid", {7'b0, out_valid}, 8'h01);
      chk("bp_data", out_data, 8'hCA);
      chk("bp_in_ready", {7'b0, in_ready}, 8'h00);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release", {7'b0, out_valid}, 8'h00);
    drain();

    // in_valid held through CALC/DONE: the second byte lands on the first
    // IDLE edge, 9 cycles after the first acceptance.
    n_acc = 0;
    t0 = 0;
    t1 = 0;
    in_valid = 1'b1;
    in_data = 8'h53;
    for (int c = 0; c < 60 && n_acc < 2; c++) begin
      @(negedge clk);
      a = in_ready & in_valid;
      @(posedge clk);
      if (a) begin
        exp_q.push_back(in_data);
        if (n_acc == 0) t0 = c; else t1 = c;
        n_acc++;
      end
      #1;
      in_data = 8'h11;
    end
    in_valid = 1'b0;
    chk("busy_accepts", 8'(n_acc), 8'd2);
    chk("busy_gap", 8'(t1 - t0), 8'd9);
    drain();

    // Asynchronous reset mid-iteration (cnt==3).
    send(8'h53);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_out_valid", {7'b0, out_valid}, 8'h00);
    chk("arst_out_data", out_data, 8'h00);
    chk("arst_busy", {7'b0, busy}, 8'h00);
    chk("arst_in_ready", {7'b0, in_ready}, 8'h00);
    void'(exp_q.pop_back());
    @(posedge clk);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    chk("arst_release_ready", {7'b0, in_ready}, 8'h01);
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
      chk("arst_no_result", {7'b0, out_valid}, 8'h00);
    end
    send(8'h02);
    wait_out();
    chk("arst_next", out_data, 8'h8D);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
